fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage plus IF/ID pipeline register. Holds the PC, issues one-outstanding
//   requests to instruction memory, and presents the fetched word to decode; if_id_imm_o
//   (instr[15:0]) feeds the decode-stage sign extender. Handles stall, branch/jump redirect
//   and discard of in-flight fetches.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC loaded on reset (bits [1:0] must be 0)
//   NOP_INSTR 32'h0000_0000  value driven on if_id_instr_o while invalid/after reset
// PORTS
//   clk             in   1   clock, all state updates on rising edge
//   rst_n           in   1   synchronous reset, active low
//   stall_i         in   1   decode cannot accept; IF/ID register holds
//   redirect_i      in   1   taken branch/jump; flush and refetch from redirect_pc_i
//   redirect_pc_i   in   32  redirect target; bits [1:0] ignored (forced 00)
//   imem_req_o      out  1   fetch request; held high with stable addr until imem_rvalid_i
//   imem_addr_o     out  32  fetch byte address, word aligned
//   imem_rvalid_i   in   1   response valid for the outstanding request (only while req high)
//   imem_rdata_i    in   32  fetched instruction word
//   if_id_valid_o   out  1   IF/ID holds a real instruction
//   if_id_instr_o   out  32  instruction to decode
//   if_id_pc4_o     out  32  address of instruction + 4
//   if_id_imm_o     out  16  if_id_instr_o[15:0], to sign extender
// BEHAVIOUR
//   Clock: one domain. Reset: synchronous, active low; while rst_n=0 at an edge:
//     pc<=RESET_PC, state<=REQ, imem_req_o=0, if_id_valid_o=0, if_id_instr_o=NOP_INSTR,
//     if_id_pc4_o=0, skid cleared. imem_req_o is combinationally 0 while rst_n=0.
//   States: REQ (request outstanding), HOLD (word buffered, decode stalled), DROP (stale
//     request outstanding after redirect, response to be discarded).
//   imem_addr_o = req_addr register; req_addr<=pc whenever a new request starts.
//   imem_req_o = 1 in REQ and DROP, 0 in HOLD.
//   REQ:  rvalid&redirect -> discard, pc<=redirect_pc, stay REQ (new request next cycle).
//         rvalid&!stall   -> load IF/ID (valid=1, instr=rdata, pc4=req_addr+4), pc<=pc+4, REQ.
//         rvalid&stall    -> capture rdata into skid, HOLD.
//         !rvalid&redirect-> pc<=redirect_pc, DROP (addr stays at stale address).
//   HOLD: redirect -> discard skid, pc<=redirect_pc, REQ.
//         !stall   -> load IF/ID from skid, pc<=pc+4, REQ.   stall -> stay HOLD.
//   DROP: rvalid -> discard, REQ with current pc. redirect -> pc<=newest redirect_pc, stay.
//   IF/ID register priority: redirect (valid<=0) > stall (hold all) > load > bubble (valid<=0).
//   Latency: rvalid in cycle N -> if_id_valid_o=1 in N+1 (zero-wait memory: 1 instr / 2 cycles
//     is NOT acceptable; a new request starts in the cycle after load, giving 1 instr/cycle
//     when rvalid is returned the same cycle as req).
//   Arithmetic: pc and pc4 are 32-bit, wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
//   Redirect and stall same cycle: redirect wins; IF/ID flushed, stall ignored.
//   Instruction never lost or duplicated: each accepted rdata reaches IF/ID exactly once
//     unless discarded by redirect.
// TESTING
//   1 Reset, zero-wait memory returning addr as data -> if_id_instr 0,4,8,... one per cycle,
//     pc4 = instr+4, imm = instr[15:0].
//   2 stall_i high 3 cycles when rvalid arrives -> HOLD, req low, IF/ID frozen; release ->
//     buffered word appears next cycle, no duplicate, no gap in sequence.
//   3 redirect_i to 32'h0000_0100 while request to 0x10 pending (rvalid 2 cycles later) ->
//     DROP, 0x10 data discarded, next req addr 0x100, IF/ID valid=0 until 0x100 word.
//   4 redirect with stall same cycle -> valid=0 next cycle; redirect_pc_i=32'h0000_0203 ->
//     fetch address 32'h0000_0200.
//   5 redirect_pc_i=32'hFFFF_FFFC -> pc4 out = 32'hFFFF_FFFC+4 = 0, next fetch addr 0.
//   6 rst_n low mid-DROP with rvalid pending -> next cycle req=0, valid=0, pc=RESET_PC; after
//     release first req addr = RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage with the IF/ID pipeline register. It holds the PC
//   and keeps a single request outstanding to instruction memory. The fetched
//   word is presented to decode together with its address + 4. The low 16 bits
//   of the instruction are brought out separately for the decode-stage sign
//   extender. The stage handles decode stalls, branch/jump redirects, and
//   discarding of fetches that are still in flight when a redirect occurs.
//
// Parameters
//   RESET_PC   PC loaded on reset (word aligned)
//   NOP_INSTR  value shown on if_id_instr_o while IF/ID is empty
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   stall_i                  decode cannot accept; IF/ID holds
//   redirect_i/_pc_i         taken branch/jump and its target (bits [1:0] ignored)
//   imem_req_o/_addr_o       fetch request and word-aligned byte address
//   imem_rvalid_i/_rdata_i   response for the outstanding request
//   if_id_valid_o            IF/ID holds a real instruction
//   if_id_instr_o            instruction to decode
//   if_id_pc4_o              address of that instruction + 4
//   if_id_imm_o              if_id_instr_o[15:0]
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o,
    output logic [15:0] if_id_imm_o
);

    // REQ : request outstanding for req_addr_reg
    // HOLD: response captured in skid_reg, waiting for decode to accept it
    // DROP: stale request still outstanding after a redirect; its data is discarded
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_HOLD = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] req_addr_reg;
    logic [31:0] skid_reg;
    logic        if_id_valid_reg;
    logic [31:0] if_id_instr_reg;
    logic [31:0] if_id_pc4_reg;

    logic [31:0] redirect_pc_aligned;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_pc4;
    logic        load_if_id;
    logic [31:0] load_instr;
    logic [31:0] drop_restart_pc;

    // Masking keeps every bit of the target port in use while forcing word alignment.
    assign redirect_pc_aligned = redirect_pc_i & 32'hFFFF_FFFC;
    assign pc_plus4            = pc_reg + 32'd4;
    assign fetch_pc4           = req_addr_reg + 32'd4;

    // Words reach IF/ID either straight from memory or from the skid buffer.
    assign load_if_id = !redirect_i && !stall_i &&
                        (((state_reg == ST_REQ) && imem_rvalid_i) || (state_reg == ST_HOLD));
    assign load_instr = (state_reg == ST_HOLD) ? skid_reg : imem_rdata_i;

    // A redirect in the same cycle as the stale response still wins.
    assign drop_restart_pc = redirect_i ? redirect_pc_aligned : pc_reg;

    // The request is gated by reset so memory never sees a request during reset.
    assign imem_req_o    = rst_n && (state_reg != ST_HOLD);
    assign imem_addr_o   = req_addr_reg;
    assign if_id_valid_o = if_id_valid_reg;
    assign if_id_instr_o = if_id_instr_reg;
    assign if_id_pc4_o   = if_id_pc4_reg;
    assign if_id_imm_o   = if_id_instr_reg[15:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_REQ;
            pc_reg          <= RESET_PC;
            req_addr_reg    <= RESET_PC;
            skid_reg        <= 32'd0;
            if_id_valid_reg <= 1'b0;
            if_id_instr_reg <= NOP_INSTR;
            if_id_pc4_reg   <= 32'd0;
        end else begin
            case (state_reg)
                ST_REQ: begin
                    if (imem_rvalid_i) begin
                        if (redirect_i) begin
                            // Wrong-path word: drop it and fetch the target next cycle.
                            pc_reg       <= redirect_pc_aligned;
                            req_addr_reg <= redirect_pc_aligned;
                        end else if (!stall_i) begin
                            // Next request starts right away for one word per cycle.
                            pc_reg       <= pc_plus4;
                            req_addr_reg <= pc_plus4;
                        end else begin
                            skid_reg  <= imem_rdata_i;
                            state_reg <= ST_HOLD;
                        end
                    end else if (redirect_i) begin
                        // Memory must still answer the old address; wait it out.
                        pc_reg    <= redirect_pc_aligned;
                        state_reg <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (redirect_i) begin
                        pc_reg       <= redirect_pc_aligned;
                        req_addr_reg <= redirect_pc_aligned;
                        state_reg    <= ST_REQ;
                    end else if (!stall_i) begin
                        pc_reg       <= pc_plus4;
                        req_addr_reg <= pc_plus4;
                        state_reg    <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid_i) begin
                        pc_reg       <= drop_restart_pc;
                        req_addr_reg <= drop_restart_pc;
                        state_reg    <= ST_REQ;
                    end else if (redirect_i) begin
                        pc_reg <= redirect_pc_aligned;
                    end
                end
                default: begin
                    state_reg <= ST_REQ;
                end
            endcase

            // IF/ID: redirect flush > stall hold > load > bubble
            if (redirect_i) begin
                if_id_valid_reg <= 1'b0;
                if_id_instr_reg <= NOP_INSTR;
            end else if (stall_i) begin
                if_id_valid_reg <= if_id_valid_reg;
            end else if (load_if_id) begin
                if_id_valid_reg <= 1'b1;
                if_id_instr_reg <= load_instr;
                if_id_pc4_reg   <= fetch_pc4;
            end else begin
                if_id_valid_reg <= 1'b0;
                if_id_instr_reg <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A behavioural instruction memory
//   returns each fetch address as its data, after a configurable wait. Every
//   response that lies on the program path is pushed to a scoreboard queue.
//   A redirect or reset flushes the queue. Each new instruction presented in
//   IF/ID is popped and compared against the queue.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc4_o;
    logic [15:0] if_id_imm_o;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_id_valid_o (if_id_valid_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_imm_o   (if_id_imm_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    int          pres_cnt;
    int          mem_lat;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic [31:0] exp_pc;
    logic [31:0] last_exp;
    logic [31:0] sb[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // A new instruction is in IF/ID: pop and compare it with the scoreboard.
    task automatic present();
        logic [31:0] a;
        check("pop_avail", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            a = sb.pop_front();
            check("instr", if_id_instr_o, a);
            check("pc4", if_id_pc4_o, a + 32'd4);
            check("imm", {16'h0000, if_id_imm_o}, {16'h0000, a[15:0]});
            last_exp = a;
            pres_cnt++;
            $display("txn if_id instr=%08h pc4=%08h imm=%04h", if_id_instr_o, if_id_pc4_o, if_id_imm_o);
        end
    endtask

    // One clock cycle. At the falling edge this task first does two things:
    // it accounts for the rising edge that has just passed, whose inputs are
    // still applied, and it updates the scoreboard. It then applies the new
    // inputs. Finally, it lets the memory decide the response for the next
    // rising edge.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc, input logic rs);
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            exp_pc = RESET_PC;
        end else if (redirect_i) begin
            sb.delete();
            exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
        end else begin
            if (imem_rvalid_i && (imem_rdata_i == exp_pc)) begin
                sb.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (!stall_i && if_id_valid_o) present();
        end

        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        rst_n         = rs;
        #1;

        if (imem_req_o) begin
            if (mem_cnt == 0) mem_addr = imem_addr_o;
            else check("addr_stable", imem_addr_o, mem_addr);
            if (mem_cnt >= mem_lat) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = imem_addr_o;
                mem_cnt       = 0;
            end else begin
                imem_rvalid_i = 1'b0;
                mem_cnt++;
            end
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hDEAD_BEEF;
            mem_cnt       = 0;
        end
    endtask

    int base;

    initial begin
        n_checks = 0; n_errors = 0; pres_cnt = 0;
        mem_lat = 0; mem_cnt = 0; mem_addr = 32'd0;
        exp_pc = RESET_PC; last_exp = 32'd0;
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;

        // Reset state
        tick(0, 0, 32'd0, 0);
        tick(0, 0, 32'd0, 0);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(if_id_valid_o), 32'd0);
        check("rst_instr", if_id_instr_o, NOP_INSTR);
        check("rst_pc4", if_id_pc4_o, 32'd0);

        // 1: zero-wait memory, one instruction per cycle
        tick(0, 0, 32'd0, 1);
        check("first_req", 32'(imem_req_o), 32'd1);
        check("first_addr", imem_addr_o, RESET_PC);
        base = pres_cnt;
        repeat (10) tick(0, 0, 32'd0, 1);
        check("throughput", 32'(pres_cnt - base), 32'd10);

        // 2: stall for three cycles while a response arrives
        tick(1, 0, 32'd0, 1);
        for (int i = 0; i < 3; i++) begin
            tick((i < 2), 0, 32'd0, 1);
            check("hold_req", 32'(imem_req_o), 32'd0);
            check("hold_valid", 32'(if_id_valid_o), 32'd1);
            check("hold_instr", if_id_instr_o, last_exp);
        end
        tick(0, 0, 32'd0, 1);
        check("release_addr", imem_addr_o, last_exp + 32'd4);
        repeat (3) tick(0, 0, 32'd0, 1);

        // 3: redirect while the request to 0x10 is pending
        tick(0, 1, 32'h0000_0010, 1);
        mem_lat = 2;
        tick(0, 1, 32'h0000_0100, 1);
        check("r3_addr_a", imem_addr_o, 32'h0000_0010);
        check("r3_valid_a", 32'(if_id_valid_o), 32'd0);
        tick(0, 0, 32'd0, 1);
        check("drop_req", 32'(imem_req_o), 32'd1);
        check("drop_addr", imem_addr_o, 32'h0000_0010);
        check("drop_valid", 32'(if_id_valid_o), 32'd0);
        tick(0, 0, 32'd0, 1);
        check("drop_valid2", 32'(if_id_valid_o), 32'd0);
        mem_lat = 0;
        tick(0, 0, 32'd0, 1);
        check("r3_new_addr", imem_addr_o, 32'h0000_0100);
        check("r3_valid_b", 32'(if_id_valid_o), 32'd0);
        tick(0, 0, 32'd0, 1);
        check("r3_valid_c", 32'(if_id_valid_o), 32'd1);
        repeat (2) tick(0, 0, 32'd0, 1);

        // 4a: redirect and stall together while a request is outstanding
        tick(1, 1, 32'h0000_0203, 1);
        tick(0, 0, 32'd0, 1);
        check("rs_valid", 32'(if_id_valid_o), 32'd0);
        check("rs_addr", imem_addr_o, 32'h0000_0200);
        repeat (2) tick(0, 0, 32'd0, 1);

        // 4b: redirect and stall together while a word is buffered
        tick(1, 0, 32'd0, 1);
        tick(1, 1, 32'h0000_0303, 1);
        check("rh_req", 32'(imem_req_o), 32'd0);
        tick(0, 0, 32'd0, 1);
        check("rh_valid", 32'(if_id_valid_o), 32'd0);
        check("rh_addr", imem_addr_o, 32'h0000_0300);
        check("rh_req2", 32'(imem_req_o), 32'd1);
        repeat (2) tick(0, 0, 32'd0, 1);

        // 5: address wrap
        tick(0, 1, 32'hFFFF_FFFC, 1);
        tick(0, 0, 32'd0, 1);
        check("wrap_addr_a", imem_addr_o, 32'hFFFF_FFFC);
        tick(0, 0, 32'd0, 1);
        check("wrap_pc4", if_id_pc4_o, 32'd0);
        check("wrap_addr_b", imem_addr_o, 32'd0);
        repeat (2) tick(0, 0, 32'd0, 1);

        // 6: reset during DROP with a response still pending
        mem_lat = 3;
        tick(0, 0, 32'd0, 1);
        tick(0, 1, 32'h0000_0040, 1);
        tick(0, 0, 32'd0, 0);
        check("r6_req_comb", 32'(imem_req_o), 32'd0);
        tick(0, 0, 32'd0, 0);
        check("r6_req", 32'(imem_req_o), 32'd0);
        check("r6_valid", 32'(if_id_valid_o), 32'd0);
        check("r6_instr", if_id_instr_o, NOP_INSTR);
        mem_lat = 0;
        tick(0, 0, 32'd0, 1);
        check("r6_req_rel", 32'(imem_req_o), 32'd1);
        check("r6_addr", imem_addr_o, RESET_PC);
        repeat (5) tick(0, 0, 32'd0, 1);

        // Stop memory and make sure nothing accepted was lost
        mem_lat = 1000;
        repeat (3) tick(0, 0, 32'd0, 1);
        check("drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
